// File: rtl/exc_ctrl.sv
// exc_ctrl: sequences exception entry and ERET return for the MEM stage
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exception_type,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delay_slot,
  input  logic [31:0] mem_bad_addr,
  input  logic        mem_stall,
  input  logic [31:0] cp0_epc,
  output logic        hold_req,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        exc_commit,
  output logic [4:0]  exc_code,
  output logic [31:0] epc_out,
  output logic        bd_out,
  output logic        badvaddr_we,
  output logic [31:0] badvaddr_out,
  output logic        eret_commit
);
  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, DRAIN} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [31:0] cap_type, cap_pc, cap_bad, cap_epc;
  logic cap_bd, cap_eret, cap_badv;
  logic [31:0] src_type, src_pc, src_bad, src_epc;
  logic src_bd, src_eret, src_badv, exc_seen;
  logic [4:0] src_code;
  assign exc_seen = exception_type != 32'd0;
  // capture and the move into COMMIT share one edge from IDLE, so commit data comes straight from MEM there
  assign src_type = state == IDLE ? exception_type : cap_type;
  assign src_pc = state == IDLE ? mem_pc : cap_pc;
  assign src_bad = state == IDLE ? mem_bad_addr : cap_bad;
  assign src_epc = state == IDLE ? cp0_epc : cap_epc;
  assign src_bd = state == IDLE ? mem_in_delay_slot : cap_bd;
  assign src_eret = src_type == 32'd14;
  assign src_badv = src_type == 32'd4 || src_type == 32'd5;
  assign cap_eret = cap_type == 32'd14;
  assign cap_badv = cap_type == 32'd4 || cap_type == 32'd5;
  // unknown nonzero codes are committed as reserved instruction
  assign src_code = src_type == 32'd1 ? 5'd0 :
                    (src_type == 32'd4 || src_type == 32'd5 || src_type == 32'd8 ||
                     src_type == 32'd9 || src_type == 32'd12 || src_type == 32'd13) ? src_type[4:0] : 5'd10;
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  // next state: one exception in flight, MEM ignored outside IDLE
  always_comb begin
    state_n = state == IDLE   ? (exc_seen ? (mem_stall ? WAIT : COMMIT) : IDLE) :
              state == WAIT   ? (mem_stall ? WAIT : COMMIT) :
              state == COMMIT ? (FLUSH_CYCLES > 0 ? DRAIN : IDLE) :
                                (cnt <= 4'd1 ? IDLE : DRAIN);
  end
  // capture registers, drain counter and held commit data
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
      cap_type <= 32'd0;
      cap_pc <= 32'd0;
      cap_bad <= 32'd0;
      cap_epc <= 32'd0;
      cap_bd <= 1'b0;
      redirect_pc <= 32'd0;
      exc_code <= 5'd0;
      epc_out <= 32'd0;
      bd_out <= 1'b0;
      badvaddr_out <= 32'd0;
    end else begin
      if (state == IDLE && exc_seen) begin
        cap_type <= exception_type;
        cap_pc <= mem_pc;
        cap_bad <= mem_bad_addr;
        cap_epc <= cp0_epc;
        cap_bd <= mem_in_delay_slot;
      end
      cnt <= state == COMMIT ? 4'(FLUSH_CYCLES) : (state == DRAIN && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      if (state_n == COMMIT) begin
        redirect_pc <= src_eret ? src_epc : EXC_VECTOR;
        if (!src_eret) begin
          exc_code <= src_code;
          epc_out <= src_bd ? src_pc - 32'd4 : src_pc;
          bd_out <= src_bd;
        end
        if (src_badv) badvaddr_out <= src_bad;
      end
    end
  end
  // strobes decode registered state only; hold_req additionally watches MEM while IDLE
  always_comb begin
    flush = state == COMMIT || state == DRAIN;
    redirect_valid = state == COMMIT;
    exc_commit = state == COMMIT && !cap_eret;
    eret_commit = state == COMMIT && cap_eret;
    badvaddr_we = state == COMMIT && cap_badv;
    hold_req = !rst && (state == WAIT || state == COMMIT || (state == IDLE && exc_seen));
  end
endmodule
